alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Datapath end of the ALU control interface: consumes decoded control fields (logic_op, shift_select, carry_select) plus two operands and produces a registered result and flags.
- Sits downstream of the operation decoder.
- Holds the architectural carry flag used as "prev carry" by addc/incc/subb.
- One-deep registered output stage with valid/ready handshake toward the register-file writeback.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  operation accepted this cycle when in_valid && in_ready
- logic_op  input  4  logic-unit truth table
- shift_select  input  2  lhs path select
- carry_select  input  2  carry-in select
- lhs  input  WIDTH  left operand
- rhs  input  WIDTH  right operand
- flag_load  input  1  restore carry flag from carry_in_restore
- carry_in_restore  input  1  value loaded by flag_load
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- carry  output  1  architectural carry flag (live register)
- zero  output  1  registered: result == 0
- negative  output  1  registered: result[WIDTH-1]

Behaviour:
- Reset (reset_n low at clk edge): out_valid=0, result=0, carry=0, zero=0, negative=0. in_ready is 0 while reset_n is low. Reset mid-operation discards the held result.
- Shift path S by shift_select:
  - 00: lhs
  - 01: lhs<<1, LSB 0
  - 10: lhs>>1, MSB 0
  - 11: all zeros
- Logic path L, per bit i: L[i] = logic_op[{rhs[i], lhs[i]}] (index bit1 = rhs, bit0 = lhs). Encodings: 0000→0, 1100→rhs, 0011→~rhs, 1111→all ones, 1000→AND, 1110→OR, 0110→XOR.
- Carry-in by carry_select:
  - 00: 0
  - 01: current carry register
  - 10: 1
  - 11: 0
- Sum: {cout, sum} = S + L + cin, computed at WIDTH+1 bits. result = sum[WIDTH-1:0].
- Handshake:
  - in_ready = reset_n && !flag_load && (!out_valid || out_ready).
  - On accept: result, zero and negative register from sum; carry register ← cout; out_valid ← 1. Latency is one cycle.
  - Output held stable while out_valid && !out_ready.
  - out_valid clears on out_ready when there is no simultaneous accept.
  - Simultaneous out_ready and accept: new result replaces the old one, out_valid stays 1 (full throughput).
- The carry register updates at accept time, not at output drain. Back-to-back addc therefore chains correctly even under backpressure.
- flag_load: carry ← carry_in_restore that cycle. in_ready is forced low, so no accept occurs; the output stage is unaffected.
- No-op (000000/00 fields, lhs passes) is still a normal accepted operation; the carry register takes cout=0.
- Wrap-around: 8'hFF+8'h01 gives result 00, carry 1, zero 1.
- Shifted-out bit is discarded; it does not affect carry.

Optional Feature:
- ALU_OVERFLOW_FLAG_EN
- Defined:
  - adds output port `overflow` (1 bit), reset 0.
  - overflow registers on accept as (S[MSB]==L[MSB]) && (sum[MSB]!=S[MSB]), i.e. signed overflow of S+L+cin.
  - Held with result under backpressure.
- Undefined: port absent, no overflow logic.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 → in_ready=0, out_valid=0, result=0, carry=0. Release → first op accepted next edge.
- add (00/00/1100), lhs=8'hF0, rhs=8'h20 → result=8'h10, carry=1, zero=0. Then addc (01/00/1100), lhs=0, rhs=0 → result=8'h01, carry=0.
- sub (10/00/0011), lhs=5, rhs=5 → result=0, carry=1, zero=1. subb with carry=0, lhs=5, rhs=3 → result=1; dec (00/00/1111) lhs=0 → result=8'hFF, negative=1, carry=0.
- Logic/shift:
  - and (00/11/1000), 8'hCC&8'hAA → 8'h88
  - or → 8'hEE
  - xor → 8'h66
  - not rhs=8'h0F → 8'hF0
  - shl lhs=8'h81 → 8'h02
  - shr lhs=8'h81 → 8'h40
- Backpressure: out_ready=0 after one accept → in_ready=0, result stable for 5 cycles. Then out_ready=1 with in_valid=1 → new result next edge, out_valid stays 1.
- flag_load=1, carry_in_restore=1, in_valid=1 → no accept that cycle, carry=1. Next incc (01/00/0000) lhs=8'h7F → result=8'h80; with ALU_OVERFLOW_FLAG_EN, overflow=1.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: datapath end of the ALU control interface.
//
// Combines a shift path (from lhs) and a bitwise logic path (from lhs/rhs
// through a 4-entry truth table) with a selectable carry-in, then registers
// the sum into a one-deep output stage with a valid/ready handshake.
// Also owns the architectural carry flag used by addc/incc/subb.
//
// Optional feature macro: ALU_OVERFLOW_FLAG_EN (adds registered signed
// overflow output `overflow`).
//
// Ports:
//   clk              system clock, rising edge
//   reset_n          synchronous active-low reset
//   in_valid         operation presented
//   in_ready         operation accepted when in_valid && in_ready
//   logic_op[3:0]    logic-unit truth table, indexed by {rhs[i], lhs[i]}
//   shift_select[1:0] lhs path: 00 pass, 01 shl, 10 shr, 11 zero
//   carry_select[1:0] carry-in: 00 zero, 01 carry flag, 10 one, 11 zero
//   lhs, rhs         operands
//   flag_load        restore carry flag from carry_in_restore (blocks accept)
//   carry_in_restore value loaded by flag_load
//   out_valid        result/flags valid
//   out_ready        downstream accepts result
//   result           registered result
//   carry            architectural carry flag (live register)
//   zero             registered result == 0
//   negative         registered result MSB
//   overflow         registered signed overflow (ALU_OVERFLOW_FLAG_EN only)

module alu_exec #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       logic_op,
    input  logic [1:0]       shift_select,
    input  logic [1:0]       carry_select,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             flag_load,
    input  logic             carry_in_restore,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] s_val;
    logic [WIDTH-1:0] l_val;
    logic             cin;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             accept;

    always_comb begin
        s_val = '0;
        unique case (shift_select)
            2'b00:   s_val = lhs;
            2'b01:   s_val = {lhs[WIDTH-2:0], 1'b0};
            2'b10:   s_val = {1'b0, lhs[WIDTH-1:1]};
            default: s_val = '0;
        endcase
    end

    always_comb begin
        l_val = '0;
        for (int i = 0; i < WIDTH; i++) begin
            l_val[i] = logic_op[{rhs[i], lhs[i]}];
        end
    end

    always_comb begin
        cin = 1'b0;
        unique case (carry_select)
            2'b01:   cin = carry;
            2'b10:   cin = 1'b1;
            default: cin = 1'b0;
        endcase
    end

    // Bit shifted out of the shift path is already gone here, so it never
    // reaches cout.
    assign sum_full = {1'b0, s_val} + {1'b0, l_val} + {{WIDTH{1'b0}}, cin};
    assign sum      = sum_full[WIDTH-1:0];
    assign cout     = sum_full[WIDTH];

    assign in_ready = reset_n && !flag_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            // flag_load and accept are mutually exclusive (in_ready low).
            if (flag_load) begin
                carry <= carry_in_restore;
            end
            if (accept) begin
                out_valid <= 1'b1;
                result    <= sum;
                carry     <= cout;
                zero      <= (sum == '0);
                negative  <= sum[WIDTH-1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (accept) begin
            overflow <= (s_val[WIDTH-1] == l_val[WIDTH-1]) &&
                        (sum[WIDTH-1] != s_val[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       logic_op;
    logic [1:0]       shift_select;
    logic [1:0]       carry_select;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic             flag_load;
    logic             carry_in_restore;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    int checks = 0;
    int errors = 0;

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .logic_op         (logic_op),
        .shift_select     (shift_select),
        .carry_select     (carry_select),
        .lhs              (lhs),
        .rhs              (rhs),
        .flag_load        (flag_load),
        .carry_in_restore (carry_in_restore),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .carry            (carry),
        .zero             (zero),
        .negative         (negative)
`ifdef ALU_OVERFLOW_FLAG_EN
        ,
        .overflow         (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] cs, input logic [1:0] ss, input logic [3:0] lop,
                          input logic [7:0] a, input logic [7:0] b);
        carry_select = cs;
        shift_select = ss;
        logic_op     = lop;
        lhs          = a;
        rhs          = b;
        in_valid     = 1'b1;
    endtask

    task automatic do_op(input logic [1:0] cs, input logic [1:0] ss, input logic [3:0] lop,
                         input logic [7:0] a, input logic [7:0] b);
        set_op(cs, ss, lop, a, b);
        tick();
    endtask

    initial begin
        reset_n          = 1'b0;
        in_valid         = 1'b1;
        out_ready        = 1'b1;
        flag_load        = 1'b0;
        carry_in_restore = 1'b0;
        set_op(2'b00, 2'b00, 4'b1100, 8'hF0, 8'h20);

        // Reset with an operation presented
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_negative", negative, 0);
`ifdef ALU_OVERFLOW_FLAG_EN
        chk("rst_overflow", overflow, 0);
`endif

        // Release: add accepted on next edge
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 8'h10);
        chk("add_carry", carry, 1);
        chk("add_zero", zero, 0);

        do_op(2'b01, 2'b00, 4'b1100, 8'h00, 8'h00);   // addc
        chk("addc_result", result, 8'h01);
        chk("addc_carry", carry, 0);

        do_op(2'b10, 2'b00, 4'b0011, 8'h05, 8'h05);   // sub
        chk("sub_result", result, 8'h00);
        chk("sub_carry", carry, 1);
        chk("sub_zero", zero, 1);

        do_op(2'b00, 2'b00, 4'b0000, 8'h33, 8'h77);   // no-op
        chk("nop_result", result, 8'h33);
        chk("nop_carry", carry, 0);

        do_op(2'b01, 2'b00, 4'b0011, 8'h05, 8'h03);   // subb, carry=0
        chk("subb_result", result, 8'h01);
        chk("subb_carry", carry, 1);

        do_op(2'b00, 2'b00, 4'b1111, 8'h00, 8'h00);   // dec
        chk("dec_result", result, 8'hFF);
        chk("dec_negative", negative, 1);
        chk("dec_carry", carry, 0);

        do_op(2'b00, 2'b11, 4'b1000, 8'hCC, 8'hAA);   // and
        chk("and_result", result, 8'h88);
        chk("and_negative", negative, 1);
        do_op(2'b00, 2'b11, 4'b1110, 8'hCC, 8'hAA);   // or
        chk("or_result", result, 8'hEE);
        do_op(2'b00, 2'b11, 4'b0110, 8'hCC, 8'hAA);   // xor
        chk("xor_result", result, 8'h66);
        chk("xor_negative", negative, 0);
        do_op(2'b00, 2'b11, 4'b0011, 8'h00, 8'h0F);   // not
        chk("not_result", result, 8'hF0);
        do_op(2'b00, 2'b01, 4'b0000, 8'h81, 8'h00);   // shl
        chk("shl_result", result, 8'h02);
        chk("shl_carry", carry, 0);
        do_op(2'b00, 2'b10, 4'b0000, 8'h81, 8'h00);   // shr
        chk("shr_result", result, 8'h40);
        chk("shr_carry", carry, 0);

        do_op(2'b00, 2'b00, 4'b1100, 8'hFF, 8'h01);   // wrap
        chk("wrap_result", result, 8'h00);
        chk("wrap_carry", carry, 1);
        chk("wrap_zero", zero, 1);

        // Backpressure: held output blocks new accepts
        out_ready = 1'b0;
        set_op(2'b00, 2'b00, 4'b1100, 8'h12, 8'h34);
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 8'h00);
            chk("bp_carry", carry, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("tp_valid", out_valid, 1);
        chk("tp_result", result, 8'h46);
        chk("tp_carry", carry, 0);

        // Drain
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_result", result, 8'h46);

        // flag_load blocks accept and restores carry
        flag_load        = 1'b1;
        carry_in_restore = 1'b1;
        set_op(2'b00, 2'b00, 4'b1100, 8'h01, 8'h01);
        #1;
        chk("fl_in_ready", in_ready, 0);
        tick();
        chk("fl_carry", carry, 1);
        chk("fl_valid", out_valid, 0);
        chk("fl_result", result, 8'h46);

        flag_load = 1'b0;
        do_op(2'b01, 2'b00, 4'b0000, 8'h7F, 8'h00);   // incc
        chk("incc_valid", out_valid, 1);
        chk("incc_result", result, 8'h80);
        chk("incc_carry", carry, 0);
        chk("incc_negative", negative, 1);
`ifdef ALU_OVERFLOW_FLAG_EN
        chk("incc_overflow", overflow, 1);
`endif

        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
